tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the TDC coarse-count datapath.
- Arms and clears the external coarse counter, then enables it between a start event and a stop event.
- Captures the coarse count plus the start and stop fine codes, and presents one result word per measurement on a valid/ready interface.
- Sits between the software/readout control logic and the coarse counter / fine delay-line encoders.

Parameters:
- CNT_W, 11: width of the coarse counter value.
- FINE_W, 4: width of each fine (delay-line) code.
- TIMEOUT, 2047: coarse count at which a running measurement is aborted as timed out; must be ≤ 2^CNT_W-1.
- ID_W, 8: width of the measurement sequence number.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  request a new measurement; sampled in IDLE only.
- abort  in  1  force return to IDLE from any state.
- start_evt  in  1  start event, clk-synchronous level; rising edge used.
- stop_evt  in  1  stop event, clk-synchronous level; rising edge used.
- fine_start  in  FINE_W  fine code valid in the cycle the start edge is detected.
- fine_stop  in  FINE_W  fine code valid in the cycle the stop edge is detected.
- ctr_value  in  CNT_W  current coarse counter value.
- ctr_clear  out  1  one-cycle clear pulse to the coarse counter.
- ctr_enable  out  1  coarse counter count enable.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_coarse  out  CNT_W  captured coarse count.
- res_fine_start  out  FINE_W  captured start fine code.
- res_fine_stop  out  FINE_W  captured stop fine code.
- res_timeout  out  1  result terminated by timeout.
- res_id  out  ID_W  sequence number of the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; res_* fields 0; res_id=0.
  - Edge-detect registers for start_evt/stop_evt cleared to 0.
- Edge detect: start_edge = start_evt & ~start_q and stop_edge = stop_evt & ~stop_q. Both q registers update every cycle in every state, so a level already high before ARMED does not count as an edge.
- States: IDLE, ARMED, RUN, DONE. All outputs are registered or decoded directly from state.
- IDLE:
  - arm=1 -> ARMED, with ctr_clear=1 for exactly the first cycle in ARMED.
  - arm in any other state is ignored.
- ARMED:
  - start_edge -> RUN; capture fine_start into res_fine_start on the same edge.
  - A stop_edge in ARMED, including one coincident with start_edge, is ignored.
- RUN:
  - ctr_enable=1 for every cycle in RUN and 0 in all other states.
  - stop_edge -> DONE; capture ctr_value into res_coarse and fine_stop into res_fine_stop; res_timeout=0.
  - Otherwise, if ctr_value ≥ TIMEOUT -> DONE; res_coarse=ctr_value, res_fine_stop=0, res_timeout=1.
  - stop_edge and timeout in the same cycle: stop wins, res_timeout=0.
- DONE:
  - res_valid=1; result fields are held stable until handshake.
  - res_valid & res_ready -> IDLE with res_valid=0 next cycle, and res_id increments.
  - res_id wraps 2^ID_W-1 -> 0.
  - Latency: res_valid rises on the cycle after the stop edge is sampled.
- abort (priority over all transitions):
  - Any state -> IDLE next cycle; res_valid and ctr_enable go 0; no result is produced; res_id unchanged.
  - abort coincident with a DONE handshake: the handshake completes and res_id increments.
- Coarse count semantics: with a counter that clears on ctr_clear and increments per enabled cycle, a stop edge N cycles after the start edge gives res_coarse=N-1.

Test Plan:
- Arm, start edge at T0 (fine_start=5), stop edge at T0+20 (fine_stop=11), res_ready=1 -> res_valid for 1 cycle at T0+21; coarse=19, fine_start=5, fine_stop=11, timeout=0, id=0; busy low afterwards.
- TIMEOUT=100, arm, start, no stop -> DONE when ctr_value=100; res_timeout=1, res_coarse=100, ctr_enable low from the next cycle.
- Stop edge in the same cycle ctr_value reaches TIMEOUT -> res_timeout=0, coarse=TIMEOUT; separately, start_evt and stop_evt rising together in ARMED -> stop ignored, measurement still RUNning.
- Hold res_ready=0 for 10 cycles in DONE while arm and start/stop toggle -> result fields unchanged, no new ctr_clear; ready=1 -> IDLE; 256 back-to-back measurements -> res_id wraps 255->0.
- abort in ARMED, RUN, and DONE (ready=0) -> IDLE next cycle, res_valid=0, ctr_enable=0, res_id unchanged; reset asserted mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
- start_evt held high before arm -> no RUN until start falls and rises again.

Source files
------------

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the TDC coarse-count datapath: arms/clears the coarse
// counter, gates it between start and stop edges, and returns one result per measurement.
module tdc_meas_ctrl #(
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FINE_W  = 4,
  parameter int unsigned TIMEOUT = 2047,
  parameter int unsigned ID_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              start_evt,
  input  logic              stop_evt,
  input  logic [FINE_W-1:0] fine_start,
  input  logic [FINE_W-1:0] fine_stop,
  input  logic [CNT_W-1:0]  ctr_value,
  output logic              ctr_clear,
  output logic              ctr_enable,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_coarse,
  output logic [FINE_W-1:0] res_fine_start,
  output logic [FINE_W-1:0] res_fine_stop,
  output logic              res_timeout,
  output logic [ID_W-1:0]   res_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic start_q;
  logic stop_q;
  logic start_edge_c;
  logic stop_edge_c;
  logic timeout_hit_c;
  logic handshake_c;

  logic              ctr_clear_d;
  logic              ctr_enable_d;
  logic              busy_d;
  logic              res_valid_d;
  logic [CNT_W-1:0]  res_coarse_d;
  logic [FINE_W-1:0] res_fine_start_d;
  logic [FINE_W-1:0] res_fine_stop_d;
  logic              res_timeout_d;
  logic [ID_W-1:0]   res_id_d;

  // Edge qualifiers; a level already high before ARMED never produces an edge.
  assign start_edge_c  = start_evt & ~start_q;
  assign stop_edge_c   = stop_evt & ~stop_q;
  assign timeout_hit_c = (ctr_value >= CNT_W'(TIMEOUT));
  assign handshake_c   = (state_q == S_DONE) & res_valid & res_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d          = state_q;
    ctr_clear_d      = 1'b0;
    res_coarse_d     = res_coarse;
    res_fine_start_d = res_fine_start;
    res_fine_stop_d  = res_fine_stop;
    res_timeout_d    = res_timeout;
    res_id_d         = res_id;

    // A handshake completes even when abort arrives in the same cycle.
    if (handshake_c) begin
      res_id_d = res_id + ID_W'(1);
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d     = S_ARMED;
            ctr_clear_d = 1'b1;
          end
        end
        S_ARMED: begin
          if (start_edge_c) begin
            state_d          = S_RUN;
            res_fine_start_d = fine_start;
          end
        end
        S_RUN: begin
          // Stop edge wins over a coincident timeout.
          if (stop_edge_c) begin
            state_d         = S_DONE;
            res_coarse_d    = ctr_value;
            res_fine_stop_d = fine_stop;
            res_timeout_d   = 1'b0;
          end else if (timeout_hit_c) begin
            state_d         = S_DONE;
            res_coarse_d    = ctr_value;
            res_fine_stop_d = FINE_W'(0);
            res_timeout_d   = 1'b1;
          end
        end
        S_DONE: begin
          if (handshake_c) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ctr_enable_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
    res_valid_d  = (state_d == S_DONE);
  end

  // Output and edge-detect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      ctr_clear      <= 1'b0;
      ctr_enable     <= 1'b0;
      busy           <= 1'b0;
      res_valid      <= 1'b0;
      res_coarse     <= '0;
      res_fine_start <= '0;
      res_fine_stop  <= '0;
      res_timeout    <= 1'b0;
      res_id         <= '0;
    end else begin
      start_q        <= start_evt;
      stop_q         <= stop_evt;
      ctr_clear      <= ctr_clear_d;
      ctr_enable     <= ctr_enable_d;
      busy           <= busy_d;
      res_valid      <= res_valid_d;
      res_coarse     <= res_coarse_d;
      res_fine_start <= res_fine_start_d;
      res_fine_stop  <= res_fine_stop_d;
      res_timeout    <= res_timeout_d;
      res_id         <= res_id_d;
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: external coarse counter, per-cycle reference model and
// directed measurement scenarios with hand-computed result words.
module tb_tdc_meas_ctrl;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned FINE_W  = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned ID_W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              start_evt = 1'b0;
  logic              stop_evt = 1'b0;
  logic [FINE_W-1:0] fine_start = '0;
  logic [FINE_W-1:0] fine_stop = '0;
  logic [CNT_W-1:0]  ctr_value;
  logic              ctr_clear;
  logic              ctr_enable;
  logic              busy;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [CNT_W-1:0]  res_coarse;
  logic [FINE_W-1:0] res_fine_start;
  logic [FINE_W-1:0] res_fine_stop;
  logic              res_timeout;
  logic [ID_W-1:0]   res_id;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  tdc_meas_ctrl #(
    .CNT_W  (CNT_W),
    .FINE_W (FINE_W),
    .TIMEOUT(TIMEOUT),
    .ID_W   (ID_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .arm           (arm),
    .abort         (abort),
    .start_evt     (start_evt),
    .stop_evt      (stop_evt),
    .fine_start    (fine_start),
    .fine_stop     (fine_stop),
    .ctr_value     (ctr_value),
    .ctr_clear     (ctr_clear),
    .ctr_enable    (ctr_enable),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_coarse    (res_coarse),
    .res_fine_start(res_fine_start),
    .res_fine_stop (res_fine_stop),
    .res_timeout   (res_timeout),
    .res_id        (res_id)
  );

  always #5 clk = ~clk;

  // Coarse counter the sequencer drives: clear wins, otherwise count while enabled.
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (ctr_clear) cnt <= '0;
    else if (ctr_enable) cnt <= cnt + CNT_W'(1);
  end
  assign ctr_value = cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: measurement phase plus the result word it should be presenting.
  int               m_ph;      // 0 idle, 1 waiting for start, 2 measuring, 3 result pending
  int               m_id;
  logic             m_clear;
  logic             m_to;
  logic [CNT_W-1:0] m_coarse;
  logic [FINE_W-1:0] m_fs;
  logic [FINE_W-1:0] m_fp;
  logic             m_prev_start;
  logic             m_prev_stop;
  logic             m_se;
  logic             m_pe;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_id = 0; m_clear = 0; m_to = 0;
      m_coarse = '0; m_fs = '0; m_fp = '0;
      m_prev_start = 0; m_prev_stop = 0;
    end else begin
      m_se = start_evt && !m_prev_start;
      m_pe = stop_evt && !m_prev_stop;
      m_clear = 0;
      if (m_ph == 3 && res_ready) m_id = (m_id + 1) % 256;
      if (abort) m_ph = 0;
      else if (m_ph == 0) begin
        if (arm) begin m_ph = 1; m_clear = 1; end
      end else if (m_ph == 1) begin
        if (m_se) begin m_ph = 2; m_fs = fine_start; end
      end else if (m_ph == 2) begin
        if (m_pe) begin
          m_ph = 3; m_coarse = cnt; m_fp = fine_stop; m_to = 0;
        end else if (int'(cnt) >= int'(TIMEOUT)) begin
          m_ph = 3; m_coarse = cnt; m_fp = 0; m_to = 1;
        end
      end else if (res_ready) m_ph = 0;
      m_prev_start = start_evt;
      m_prev_stop  = stop_evt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("ctr_clear", ctr_clear, m_clear);
      check("ctr_enable", ctr_enable, int'(m_ph == 2));
      check("busy", busy, int'(m_ph != 0));
      check("res_valid", res_valid, int'(m_ph == 3));
      check("res_id", res_id, m_id);
      if (m_ph == 3) begin
        check("res_coarse", res_coarse, m_coarse);
        check("res_fine_start", res_fine_start, m_fs);
        check("res_fine_stop", res_fine_stop, m_fp);
        check("res_timeout", res_timeout, m_to);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (res_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid", int'(res_valid === 1'b1), 1);
  endtask

  // One measurement; returns at the negedge where the result is presented.
  task automatic measure(input int fs, input int fp, input int gap);
    arm = 1; tick();
    arm = 0; start_evt = 1; fine_start = FINE_W'(fs);
    tick(gap);
    stop_evt = 1; fine_stop = FINE_W'(fp); start_evt = 0;
    tick();
    stop_evt = 0;
    wait_valid(5);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_enable"}, ctr_enable, 0);
    check({tag, "_id"}, res_id, n_done % 256);
  endtask

  initial begin
    // Reset state.
    tick(2);
    check("rst_clear", ctr_clear, 0);
    check("rst_enable", ctr_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_coarse", res_coarse, 0);
    check("rst_id", res_id, 0);
    reset = 1;
    tick();

    // Basic measurement: stop 20 cycles after start.
    res_ready = 1;
    arm = 1; tick();
    arm = 0;
    check("t1_clear_pulse", ctr_clear, 1);
    start_evt = 1; fine_start = 4'd5;
    tick(20);
    stop_evt = 1; fine_stop = 4'd11; start_evt = 0;
    tick();
    stop_evt = 0;
    check("t1_valid", res_valid, 1);
    check("t1_coarse", res_coarse, 19);
    check("t1_fs", res_fine_start, 5);
    check("t1_fp", res_fine_stop, 11);
    check("t1_to", res_timeout, 0);
    check("t1_id", res_id, 0);
    tick(); n_done++;
    check("t1_valid_off", res_valid, 0);
    check("t1_busy_off", busy, 0);

    // Timeout with no stop edge.
    arm = 1; tick();
    arm = 0; start_evt = 1; fine_start = 4'd2;
    tick();
    start_evt = 0;
    wait_valid(150);
    check("t2_coarse", res_coarse, 100);
    check("t2_to", res_timeout, 1);
    check("t2_fp", res_fine_stop, 0);
    check("t2_enable", ctr_enable, 0);
    tick(); n_done++;

    // Stop edge in the same cycle the count reaches TIMEOUT.
    arm = 1; tick();
    arm = 0; start_evt = 1; fine_start = 4'd7;
    tick(101);
    stop_evt = 1; fine_stop = 4'd6; start_evt = 0;
    tick();
    stop_evt = 0;
    check("t3_valid", res_valid, 1);
    check("t3_coarse", res_coarse, 100);
    check("t3_to", res_timeout, 0);
    check("t3_fp", res_fine_stop, 6);
    tick(); n_done++;

    // Start and stop rising together in ARMED: stop ignored.
    arm = 1; tick();
    arm = 0; start_evt = 1; stop_evt = 1; fine_start = 4'd8;
    tick(3);
    check("t3b_busy", busy, 1);
    check("t3b_enable", ctr_enable, 1);
    stop_evt = 0; tick();
    stop_evt = 1; fine_stop = 4'd1; start_evt = 0;
    tick();
    stop_evt = 0;
    wait_valid(5);
    check("t3b_coarse", res_coarse, 3);
    check("t3b_to", res_timeout, 0);
    tick(); n_done++;

    // Result held while the consumer stalls; inputs toggling meanwhile.
    res_ready = 0;
    measure(3, 9, 7);
    for (int i = 0; i < 10; i++) begin
      arm = (i % 2 == 1);
      start_evt = (i % 2 == 0);
      stop_evt = (i % 3 == 0);
      tick();
      check("t4_valid", res_valid, 1);
      check("t4_clear", ctr_clear, 0);
      check("t4_coarse", res_coarse, 6);
      check("t4_fs", res_fine_start, 3);
      check("t4_fp", res_fine_stop, 9);
      check("t4_id", res_id, 4);
    end
    arm = 0; start_evt = 0; stop_evt = 0; res_ready = 1;
    tick(); n_done++;
    check("t4_release_valid", res_valid, 0);
    check("t4_release_busy", busy, 0);
    check("t4_release_id", res_id, 5);

    // Back-to-back measurements through the sequence-number wrap.
    for (int i = 0; i < 256; i++) begin
      measure(i % 16, (i * 3) % 16, 1 + i % 4);
      check("wrap_coarse", res_coarse, i % 4);
      tick(); n_done++;
    end
    check("wrap_id", res_id, 5);

    // Abort in ARMED.
    arm = 1; tick();
    arm = 0; abort = 1; tick();
    abort = 0;
    check_idle("abort_armed");

    // Abort in RUN.
    arm = 1; tick();
    arm = 0; start_evt = 1; tick(5);
    start_evt = 0; abort = 1; tick();
    abort = 0;
    check_idle("abort_run");

    // Abort in DONE with the consumer stalled.
    res_ready = 0;
    measure(4, 4, 2);
    abort = 1; tick();
    abort = 0;
    check_idle("abort_done");

    // Abort coincident with a handshake still retires the result.
    res_ready = 1;
    measure(5, 5, 2);
    abort = 1; tick(); n_done++;
    abort = 0;
    check_idle("abort_hs");

    // Asynchronous reset mid-measurement.
    arm = 1; tick();
    arm = 0; start_evt = 1; tick(5);
    start_evt = 0;
    #2 reset = 0;
    #1;
    check("arst_enable", ctr_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_clear", ctr_clear, 0);
    check("arst_valid", res_valid, 0);
    check("arst_id", res_id, 0);
    @(negedge clk);
    reset = 1; n_done = 0;
    tick();

    // Start level already high before arm is not an edge.
    start_evt = 1; tick(2);
    arm = 1; tick();
    arm = 0; tick(3);
    check("t6_busy", busy, 1);
    check("t6_no_run", ctr_enable, 0);
    start_evt = 0; tick();
    start_evt = 1; fine_start = 4'd12; tick(2);
    check("t6_run", ctr_enable, 1);
    stop_evt = 1; fine_stop = 4'd13; start_evt = 0;
    tick();
    stop_evt = 0;
    wait_valid(5);
    check("t6_coarse", res_coarse, 1);
    check("t6_fs", res_fine_start, 12);
    check("t6_id", res_id, 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
